// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the MEM-stage access engine: access sizes, FSM states,
// byte-lane enable patterns and the misalignment predicate.
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // Size 2'b11 behaves as a word, so any size with bit 1 set needs a == 0.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        if (size == SIZE_BYTE)
            return 1'b0;
        else if (size == SIZE_HALF)
            return a[0];
        else
            return (a != 2'b00);
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory req/ack bus between the MEM-stage engine (master) and the
// external data memory (slave).
interface mem_access_unit_if;
    logic        Mem_Req;
    logic        Mem_We;
    logic [31:0] Mem_Addr;
    logic [3:0]  Mem_ByteEn;
    logic [31:0] Mem_WData;
    logic [31:0] Mem_RData;
    logic        Mem_Ack;

    modport master (
        output Mem_Req, Mem_We, Mem_Addr, Mem_ByteEn, Mem_WData,
        input  Mem_RData, Mem_Ack
    );

    modport slave (
        input  Mem_Req, Mem_We, Mem_Addr, Mem_ByteEn, Mem_WData,
        output Mem_RData, Mem_Ack
    );
endinterface

// File: rtl/mem_access_unit_lane_align.sv
// Little-endian lane steering: store byte enables and lane replication, plus
// load lane extraction with sign or zero extension.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        zero_ext,
    input  logic [31:0] store_data,
    input  logic [31:0] load_raw,
    output logic [3:0]  byte_en,
    output logic [31:0] store_lanes,
    output logic [31:0] load_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte     = load_raw[{addr_lo, 3'b000} +: 8];
        ld_half     = load_raw[{addr_lo[1], 4'b0000} +: 16];
        byte_en     = BE_WORD;
        store_lanes = store_data;
        load_data   = load_raw;
        case (size)
            SIZE_BYTE: begin
                byte_en     = BE_BYTE0 << addr_lo;
                store_lanes = {4{store_data[7:0]}};
                load_data   = zero_ext ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            end
            SIZE_HALF: begin
                byte_en     = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
                store_lanes = {2{store_data[15:0]}};
                load_data   = zero_ext ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine driving a req/ack data bus with a timeout.
// Build option MEM_MISALIGN_CHECK_EN: trap misaligned half/word accesses.
//
// state   | meaning
// IDLE    | no access in flight; samples pipeline inputs
// REQ     | Mem_Req high, waiting for Mem_Ack or timeout
// DONE    | result valid, stall released for one cycle
module mem_access_unit
    import mem_pkg::*;
#(
    parameter  int TIMEOUT_CYCLES = 16,
    localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              MEM_MemRead,
    input  logic              MEM_MemWrite,
    input  logic [1:0]        MEM_Size,
    input  logic              MEM_Unsigned,
    input  logic [31:0]       MEM_Address,
    input  logic [31:0]       MEM_WriteData,
    mem_access_unit_if.master bus,
    output logic [31:0]       MEM_MemData,
    output logic              MEM_Stall,
    output logic              MEM_BusError,
    output logic              MEM_AddrExc
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              access, misalign, timeout;
    logic              req_d, we_d, bus_err_d, addr_exc_d, addr_exc_q;
    logic [31:0]       addr_d, wdata_d, mem_data_d;
    logic [3:0]        be_d;
    logic [3:0]        lane_be;
    logic [31:0]       lane_wdata, lane_rdata;

    assign access      = MEM_MemRead | MEM_MemWrite;
    assign MEM_Stall   = access & (state != ST_DONE);
    assign timeout     = (cnt == CNT_LAST);
    assign MEM_AddrExc = addr_exc_q;

`ifdef MEM_MISALIGN_CHECK_EN
    assign misalign = is_misaligned(MEM_Size, MEM_Address[1:0]);
`else
    assign misalign = 1'b0;
`endif

    // Pipeline inputs are held stable while stalled, so one instance serves
    // both the store lanes (used in IDLE) and the load extraction (used in REQ).
    mem_lane_align u_lane (
        .size        (MEM_Size),
        .addr_lo     (MEM_Address[1:0]),
        .zero_ext    (MEM_Unsigned),
        .store_data  (MEM_WriteData),
        .load_raw    (bus.Mem_RData),
        .byte_en     (lane_be),
        .store_lanes (lane_wdata),
        .load_data   (lane_rdata)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            state <= ST_IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: if (access) state_d = misalign ? ST_DONE : ST_REQ;
            ST_REQ:  if (bus.Mem_Ack || timeout) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_d      = bus.Mem_Req;
        we_d       = bus.Mem_We;
        addr_d     = bus.Mem_Addr;
        be_d       = bus.Mem_ByteEn;
        wdata_d    = bus.Mem_WData;
        mem_data_d = MEM_MemData;
        bus_err_d  = MEM_BusError;
        addr_exc_d = addr_exc_q;
        cnt_d      = cnt;
        case (state)
            ST_IDLE: begin
                if (access) begin
                    cnt_d = '0;
                    if (misalign) begin
                        addr_exc_d = 1'b1;
                        mem_data_d = 32'h0;
                    end else begin
                        req_d   = 1'b1;
                        we_d    = MEM_MemWrite;
                        addr_d  = {MEM_Address[31:2], 2'b00};
                        be_d    = lane_be;
                        wdata_d = lane_wdata;
                    end
                end
            end
            ST_REQ: begin
                cnt_d = cnt + CNT_W'(1);
                // Mem_We drops with Mem_Req so no stale write strobe lingers.
                if (bus.Mem_Ack) begin
                    req_d = 1'b0;
                    we_d  = 1'b0;
                    if (!bus.Mem_We) mem_data_d = lane_rdata;
                end else if (timeout) begin
                    req_d      = 1'b0;
                    we_d       = 1'b0;
                    mem_data_d = 32'h0;
                    bus_err_d  = 1'b1;
                end
            end
            ST_DONE: begin
                bus_err_d  = 1'b0;
                addr_exc_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            bus.Mem_Req    <= 1'b0;
            bus.Mem_We     <= 1'b0;
            bus.Mem_Addr   <= 32'h0;
            bus.Mem_ByteEn <= BE_NONE;
            bus.Mem_WData  <= 32'h0;
            MEM_MemData    <= 32'h0;
            MEM_BusError   <= 1'b0;
            addr_exc_q     <= 1'b0;
            cnt            <= '0;
        end else begin
            bus.Mem_Req    <= req_d;
            bus.Mem_We     <= we_d;
            bus.Mem_Addr   <= addr_d;
            bus.Mem_ByteEn <= be_d;
            bus.Mem_WData  <= wdata_d;
            MEM_MemData    <= mem_data_d;
            MEM_BusError   <= bus_err_d;
            addr_exc_q     <= addr_exc_d;
            cnt            <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expectations are queued at issue time
// and compared against what the DUT shows on the bus and at DONE.
module tb_mem_access_unit;
    import mem_pkg::*;

    localparam int TO = 16;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        rd_en = 1'b0, wr_en = 1'b0, uns = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = 32'h0, wd = 32'h0;
    logic [31:0] MEM_MemData;
    logic        MEM_Stall, MEM_BusError, MEM_AddrExc;

    mem_access_unit_if bus ();

    logic        ack_en = 1'b0, force_ack = 1'b0;
    int          ack_delay = 0;
    int          wait_cnt = 0;
    logic [31:0] mem_rdata = 32'h0;

    assign bus.Mem_Ack   = force_ack | (bus.Mem_Req & ack_en & (wait_cnt == ack_delay));
    assign bus.Mem_RData = mem_rdata;

    always @(posedge Clock) begin
        if (!bus.Mem_Req) wait_cnt <= 0;
        else if (!bus.Mem_Ack) wait_cnt <= wait_cnt + 1;
    end

    always #5 Clock = ~Clock;

    mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .MEM_MemRead   (rd_en),
        .MEM_MemWrite  (wr_en),
        .MEM_Size      (size),
        .MEM_Unsigned  (uns),
        .MEM_Address   (addr),
        .MEM_WriteData (wd),
        .bus           (bus),
        .MEM_MemData   (MEM_MemData),
        .MEM_Stall     (MEM_Stall),
        .MEM_BusError  (MEM_BusError),
        .MEM_AddrExc   (MEM_AddrExc)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] memdata;
        logic        buserr;
        logic        addrexc;
        int          req_cycles;
        int          stall_cycles;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] last_memdata = 32'h0;
    int          n_cmp = 0, n_bad = 0;

    logic        obs_done, obs_we, obs_buserr, obs_addrexc;
    logic [31:0] obs_addr, obs_wdata, obs_memdata;
    logic [3:0]  obs_be;
    int          obs_req_cycles, obs_stall_cycles;

    function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [1:0] a);
        logic [3:0] r;
        for (int i = 0; i < 4; i++)
            r[i] = (sz == 2'b00) ? (i == int'(a)) : (sz == 2'b01) ? ((i / 2) == int'(a[1])) : 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = (sz == 2'b00) ? d[7:0] : (sz == 2'b01) ? d[8*(i%2) +: 8] : d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic u,
                                               input logic [1:0] a, input logic [31:0] rd);
        logic [31:0] v;
        if (sz == 2'b00) begin
            v = (rd >> (8 * int'(a))) & 32'hFF;
            if (!u && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            v = (rd >> (a[1] ? 16 : 0)) & 32'hFFFF;
            if (!u && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    task automatic issue(input logic r, input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] rdat,
                         input int dly, input logic ack_on);
        exp_t e;
        logic mis;
        mis = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
        mis = ((sz == 2'b01) && a[0]) || (sz[1] && (a[1:0] != 2'b00));
`endif
        e.we      = w;
        e.addr    = {a[31:2], 2'b00};
        e.be      = model_be(sz, a[1:0]);
        e.wdata   = model_wdata(sz, d);
        e.buserr  = !ack_on && !mis;
        e.addrexc = mis;
        if (mis || !ack_on) e.memdata = 32'h0;
        else if (w)         e.memdata = last_memdata;
        else                e.memdata = model_load(sz, u, a[1:0], rdat);
        last_memdata   = e.memdata;
        e.req_cycles   = mis ? 0 : (ack_on ? dly + 1 : TO);
        e.stall_cycles = mis ? 1 : e.req_cycles + 1;
        sb.push_back(e);
        mem_rdata = rdat; ack_delay = dly; ack_en = ack_on;
        rd_en = r; wr_en = w; size = sz; uns = u; addr = a; wd = d;
    endtask

    // Observes the access from IDLE to DONE; leaves the bench just after the
    // DONE negedge with the pipeline inputs dropped.
    task automatic run_to_done(input int budget);
        obs_done = 1'b0; obs_req_cycles = 0; obs_stall_cycles = 0;
        obs_we = 1'b0; obs_addr = 32'h0; obs_be = 4'h0; obs_wdata = 32'h0;
        obs_memdata = 32'h0; obs_buserr = 1'b0; obs_addrexc = 1'b0;
        #1;
        for (int i = 0; i < budget; i++) begin
            if (bus.Mem_Req) begin
                if (obs_req_cycles == 0) begin
                    obs_we = bus.Mem_We; obs_addr = bus.Mem_Addr;
                    obs_be = bus.Mem_ByteEn; obs_wdata = bus.Mem_WData;
                end
                obs_req_cycles++;
            end
            if (MEM_Stall) begin
                obs_stall_cycles++;
            end else begin
                obs_memdata = MEM_MemData; obs_buserr = MEM_BusError;
                obs_addrexc = MEM_AddrExc; obs_done = 1'b1;
                break;
            end
            @(negedge Clock); #1;
        end
        rd_en = 1'b0; wr_en = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) @(negedge Clock);
        n_cmp++; if (bus.Mem_Req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", bus.Mem_Req); end
        n_cmp++; if (bus.Mem_We !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b want 0", bus.Mem_We); end
        n_cmp++; if (bus.Mem_Addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", bus.Mem_Addr); end
        n_cmp++; if (bus.Mem_ByteEn !== 4'h0) begin n_bad++; $display("FAIL reset_be: got %b want 0000", bus.Mem_ByteEn); end
        n_cmp++; if (bus.Mem_WData !== 32'h0) begin n_bad++; $display("FAIL reset_wdata: got %h want 0", bus.Mem_WData); end
        n_cmp++; if (MEM_MemData !== 32'h0) begin n_bad++; $display("FAIL reset_memdata: got %h want 0", MEM_MemData); end
        n_cmp++; if ({MEM_BusError, MEM_AddrExc, MEM_Stall} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {MEM_BusError, MEM_AddrExc, MEM_Stall}); end
        Reset = 1'b0;
        @(negedge Clock);
    endtask

    task automatic test_load_word();
        exp_t e;
        issue(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b1);
        run_to_done(40);
        e = sb.pop_front();
        n_cmp++; if (obs_done !== 1'b1) begin n_bad++; $display("FAIL lw_done: got %b want 1", obs_done); end
        n_cmp++; if (obs_stall_cycles != e.stall_cycles) begin n_bad++; $display("FAIL lw_stall: got %0d want %0d", obs_stall_cycles, e.stall_cycles); end
        n_cmp++; if (obs_be !== e.be) begin n_bad++; $display("FAIL lw_be: got %b want %b", obs_be, e.be); end
        n_cmp++; if (obs_addr !== e.addr) begin n_bad++; $display("FAIL lw_addr: got %h want %h", obs_addr, e.addr); end
        n_cmp++; if (obs_memdata !== e.memdata) begin n_bad++; $display("FAIL lw_data: got %h want %h", obs_memdata, e.memdata); end
        @(negedge Clock);
    endtask

    task automatic test_load_extend();
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: issue(1'b1, 1'b0, SIZE_BYTE, 1'b0, 32'h103, 32'h0, 32'h80112233, 0, 1'b1);
                1: issue(1'b1, 1'b0, SIZE_BYTE, 1'b1, 32'h103, 32'h0, 32'h80112233, 0, 1'b1);
                2: issue(1'b1, 1'b0, SIZE_HALF, 1'b0, 32'h302, 32'h0, 32'h9ABC1234, 1, 1'b1);
                default: issue(1'b1, 1'b0, SIZE_BYTE, 1'b0, 32'h301, 32'h0, 32'h00007F00, 2, 1'b1);
            endcase
            run_to_done(40);
            e = sb.pop_front();
            n_cmp++; if (obs_memdata !== e.memdata) begin n_bad++; $display("FAIL load_ext_%0d: got %h want %h", k, obs_memdata, e.memdata); end
            n_cmp++; if (obs_req_cycles != e.req_cycles) begin n_bad++; $display("FAIL load_ext_req_%0d: got %0d want %0d", k, obs_req_cycles, e.req_cycles); end
            @(negedge Clock);
        end
    endtask

    task automatic test_store();
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: issue(1'b0, 1'b1, SIZE_HALF, 1'b0, 32'h202, 32'h0000ABCD, 32'h0, 0, 1'b1);
                1: issue(1'b0, 1'b1, SIZE_BYTE, 1'b0, 32'h001, 32'h1234565A, 32'h0, 1, 1'b1);
                default: issue(1'b1, 1'b1, SIZE_WORD, 1'b0, 32'h40C, 32'hCAFEF00D, 32'h11111111, 2, 1'b1);
            endcase
            run_to_done(40);
            e = sb.pop_front();
            n_cmp++; if (obs_we !== e.we) begin n_bad++; $display("FAIL st_we_%0d: got %b want %b", k, obs_we, e.we); end
            n_cmp++; if (obs_be !== e.be) begin n_bad++; $display("FAIL st_be_%0d: got %b want %b", k, obs_be, e.be); end
            n_cmp++; if (obs_wdata !== e.wdata) begin n_bad++; $display("FAIL st_wdata_%0d: got %h want %h", k, obs_wdata, e.wdata); end
            n_cmp++; if (obs_addr !== e.addr) begin n_bad++; $display("FAIL st_addr_%0d: got %h want %h", k, obs_addr, e.addr); end
            n_cmp++; if (obs_memdata !== e.memdata) begin n_bad++; $display("FAIL st_keep_%0d: got %h want %h", k, obs_memdata, e.memdata); end
            @(negedge Clock);
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        issue(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h40, 32'h0, 32'h55AA55AA, 0, 1'b0);
        run_to_done(60);
        e = sb.pop_front();
        n_cmp++; if (obs_req_cycles != e.req_cycles) begin n_bad++; $display("FAIL to_req_cycles: got %0d want %0d", obs_req_cycles, e.req_cycles); end
        n_cmp++; if (obs_stall_cycles != e.stall_cycles) begin n_bad++; $display("FAIL to_stall: got %0d want %0d", obs_stall_cycles, e.stall_cycles); end
        n_cmp++; if (obs_buserr !== e.buserr) begin n_bad++; $display("FAIL to_buserr: got %b want %b", obs_buserr, e.buserr); end
        n_cmp++; if (obs_memdata !== e.memdata) begin n_bad++; $display("FAIL to_data: got %h want %h", obs_memdata, e.memdata); end
        @(negedge Clock); #1;
        n_cmp++; if (MEM_BusError !== 1'b0) begin n_bad++; $display("FAIL to_clear: got %b want 0", MEM_BusError); end
        ack_en = 1'b1;
        @(negedge Clock);
    endtask

    task automatic test_misalign();
        exp_t e;
        issue(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h101, 32'h0, 32'h13579BDF, 0, 1'b1);
        run_to_done(40);
        e = sb.pop_front();
        n_cmp++; if (obs_req_cycles != e.req_cycles) begin n_bad++; $display("FAIL mis_req: got %0d want %0d", obs_req_cycles, e.req_cycles); end
        n_cmp++; if (obs_stall_cycles != e.stall_cycles) begin n_bad++; $display("FAIL mis_stall: got %0d want %0d", obs_stall_cycles, e.stall_cycles); end
        n_cmp++; if (obs_addrexc !== e.addrexc) begin n_bad++; $display("FAIL mis_exc: got %b want %b", obs_addrexc, e.addrexc); end
        n_cmp++; if (obs_memdata !== e.memdata) begin n_bad++; $display("FAIL mis_data: got %h want %h", obs_memdata, e.memdata); end
        @(negedge Clock); #1;
        n_cmp++; if (MEM_AddrExc !== 1'b0) begin n_bad++; $display("FAIL mis_clear: got %b want 0", MEM_AddrExc); end
        @(negedge Clock);
    endtask

    task automatic test_reset_mid_access();
        issue(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h500, 32'h0, 32'hA5A5A5A5, 0, 1'b0);
        repeat (3) @(negedge Clock);
        #1;
        n_cmp++; if (bus.Mem_Req !== 1'b1) begin n_bad++; $display("FAIL rst_mid_pre: got %b want 1", bus.Mem_Req); end
        Reset = 1'b1;
        #1;
        n_cmp++; if (bus.Mem_Req !== 1'b0) begin n_bad++; $display("FAIL rst_mid_req: got %b want 0", bus.Mem_Req); end
        rd_en = 1'b0;
        force_ack = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        @(negedge Clock);
        Reset = 1'b0;
        repeat (2) @(negedge Clock);
        #1;
        n_cmp++; if (bus.Mem_Req !== 1'b0) begin n_bad++; $display("FAIL rst_late_ack_req: got %b want 0", bus.Mem_Req); end
        n_cmp++; if (MEM_MemData !== 32'h0) begin n_bad++; $display("FAIL rst_late_ack_data: got %h want 0", MEM_MemData); end
        n_cmp++; if ({MEM_Stall, MEM_BusError} !== 2'b00) begin n_bad++; $display("FAIL rst_late_ack_flags: got %b want 00", {MEM_Stall, MEM_BusError}); end
        force_ack = 1'b0;
        ack_en = 1'b1;
        void'(sb.pop_front());
        last_memdata = 32'h0;
        @(negedge Clock);
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [1:0]  mode, sz;
        logic [31:0] a;
        for (int k = 0; k < 12; k++) begin
            mode = 2'($urandom_range(0, 2));
            sz   = 2'($urandom_range(0, 3));
            a    = $urandom;
            issue(mode != 2'd1, mode != 2'd0, sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom,
                  int'($urandom_range(0, 3)), 1'b1);
            run_to_done(40);
            e = sb.pop_front();
            n_cmp++; if (obs_done !== 1'b1) begin n_bad++; $display("FAIL b2b_done_%0d: got %b want 1", k, obs_done); end
            n_cmp++; if (obs_stall_cycles != e.stall_cycles) begin n_bad++; $display("FAIL b2b_stall_%0d: got %0d want %0d", k, obs_stall_cycles, e.stall_cycles); end
            n_cmp++; if (obs_memdata !== e.memdata) begin n_bad++; $display("FAIL b2b_data_%0d: got %h want %h", k, obs_memdata, e.memdata); end
            n_cmp++; if ({obs_buserr, obs_addrexc} !== {e.buserr, e.addrexc}) begin n_bad++; $display("FAIL b2b_flags_%0d: got %b want %b", k, {obs_buserr, obs_addrexc}, {e.buserr, e.addrexc}); end
            if (e.req_cycles > 0) begin
                n_cmp++; if ({obs_we, obs_be, obs_addr, obs_wdata} !== {e.we, e.be, e.addr, e.wdata})
                    begin n_bad++; $display("FAIL b2b_bus_%0d: got %b/%b/%h/%h want %b/%b/%h/%h", k, obs_we, obs_be, obs_addr, obs_wdata, e.we, e.be, e.addr, e.wdata); end
            end
            @(negedge Clock);
        end
    endtask

    initial begin
        test_reset();
        ack_en = 1'b1;
        test_load_word();
        test_load_extend();
        test_store();
        test_timeout();
        test_misalign();
        test_reset_mid_access();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1);
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-access (MEM) stage engine. Sits between the EX/MEM pipeline registers and the MEM/WB pipeline registers.
- Performs loads and stores of byte, halfword and word size against an external data memory over a req/ack handshake.
- Aligns and extends load data and produces MEM_MemData for the MEM/WB registers.
- Drives MEM_Stall to freeze upstream stages, and to make the hazard logic bubble MEM/WB, while an access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 16: maximum REQ cycles without Mem_Ack before the access is aborted with a bus error. Range 2..255.
- CNT_W, $clog2(TIMEOUT_CYCLES+1): width of the wait counter. Derived; not to be overridden.

Ports:
- Clock  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high; resets all state immediately.
- MEM_MemRead  in  1  load request from EX/MEM.
- MEM_MemWrite  in  1  store request from EX/MEM.
- MEM_Size  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
- MEM_Unsigned  in  1  1 = zero-extend loads (lbu/lhu); 0 = sign-extend.
- MEM_Address  in  32  byte address (ALU result).
- MEM_WriteData  in  32  store data, right-justified.
- Mem_Req  out  1  bus request, registered.
- Mem_We  out  1  1 = write, registered.
- Mem_Addr  out  32  word address, {MEM_Address[31:2],2'b00}, registered.
- Mem_ByteEn  out  4  byte-lane enables, registered.
- Mem_WData  out  32  lane-replicated store data, registered.
- Mem_RData  in  32  read data; valid in the cycle Mem_Ack=1.
- Mem_Ack  in  1  access complete.
- MEM_MemData  out  32  aligned and extended load result, registered.
- MEM_Stall  out  1  combinational; 1 = hold upstream and insert a MEM/WB bubble.
- MEM_BusError  out  1  registered; 1 during DONE if the access timed out.
- MEM_AddrExc  out  1  registered; misalignment flag (see Optional Feature).

Behaviour:
- Reset values: Mem_Req=0, Mem_We=0, Mem_Addr=0, Mem_ByteEn=0, Mem_WData=0, MEM_MemData=0, MEM_BusError=0, MEM_AddrExc=0, state=IDLE, counter=0.
- Access = MEM_MemRead | MEM_MemWrite. If both are high, the access is a write.
- MEM_Stall = Access & (state != DONE).
- FSM states:
  - IDLE: if Access, latch the bus outputs, set Mem_Req=1, clear the counter, go to REQ. Otherwise stay in IDLE.
  - REQ: Mem_Req held at 1; counter increments each cycle.
    - On Mem_Ack=1: Mem_Req=0; for reads, MEM_MemData <= aligned(Mem_RData); go to DONE.
    - Else, if counter == TIMEOUT_CYCLES-1: Mem_Req=0, MEM_MemData=0, MEM_BusError=1; go to DONE.
  - DONE: stall released, so the pipeline advances on this edge. Next state is IDLE; MEM_BusError and MEM_AddrExc clear on leaving DONE.
- Latency: zero-wait memory gives 3 cycles (IDLE, REQ, DONE). Each wait cycle adds 1.
- Stores leave MEM_MemData unchanged.
- Byte lanes (little-endian, a = MEM_Address[1:0]):
  - byte: ByteEn = 1<<a; WData = {4{wd[7:0]}}.
  - half: ByteEn = a[1] ? 1100 : 0011; WData = {2{wd[15:0]}}.
  - word: ByteEn = 1111; WData = wd.
- Loads select the same lanes from Mem_RData, then sign- or zero-extend to 32 bits per MEM_Unsigned.
- Mem_Ack is ignored in IDLE and DONE.
- Reset asserted mid-access: the FSM returns to IDLE and Mem_Req drops immediately. A late Mem_Ack after reset is ignored.
- Inputs must be held stable by upstream while MEM_Stall=1. They are sampled only in IDLE.

Optional Feature:
- Macro: MEM_MISALIGN_CHECK_EN.
- Defined: a half access with a[0]=1, or a word access with a!=0, issues no bus request. IDLE goes directly to DONE with MEM_AddrExc=1, MEM_MemData=0, and no memory write.
- Undefined: low address bits below the access size are ignored (half uses a[1] only; word ignores a). MEM_AddrExc is tied 0.

Decomposition:
- Package mem_pkg holds:
  - size encodings SIZE_BYTE, SIZE_HALF, SIZE_WORD;
  - state encodings ST_IDLE, ST_REQ, ST_DONE;
  - byte-enable constants.
- One combinational sub-module, mem_lane_align, produces store lane/enable generation and load extraction/extension. It is instanced once for the store path and once for the load path, or as a single instance with both functions.

Test Plan:
- lw, addr 0x100, Mem_RData=0xDEADBEEF, ack in 1st REQ cycle -> MEM_Stall high for 2 cycles; MEM_MemData=0xDEADBEEF in DONE; Mem_ByteEn=1111.
- lb, addr 0x103, RData=0x80112233, signed -> MEM_MemData=0xFFFFFF80. Same access with lbu -> 0x00000080.
- sh, addr 0x202, wd=0x0000ABCD -> Mem_We=1, Mem_ByteEn=1100, Mem_WData=0xABCDABCD, Mem_Addr=0x200.
- No ack, TIMEOUT_CYCLES=16 -> Mem_Req high for exactly 16 cycles; DONE with MEM_BusError=1 and MEM_MemData=0.
- Reset pulsed during REQ, then ack arrives -> Mem_Req=0 immediately; state IDLE; MEM_MemData stays 0.
- With MEM_MISALIGN_CHECK_EN, lw addr 0x101 -> Mem_Req never asserts; MEM_AddrExc=1 for one cycle; stall lasts 1 cycle.
